ag32gbd_ram_rd: RTL and testbench

Cartridge-bus read responder for the camera's photo RAM window (A000–BFFF, RAM banks 0x00–0x0F). It is the read-side counterpart of the register/dither write path. On a Game Boy read cycle it latches the address, fetches one byte from the frame memory over a req/ack port, and presents it for the top-level Cart_d tristate until nCS deasserts. Bank 0x10 reads (register space) are not handled here.

---
 rtl/ag32gbd_pkg.sv | 21 ++
 rtl/ag32gbd_sync2.sv | 22 ++
 rtl/ag32gbd_ram_rd.sv | 151 +++++++++++++++
 tb/tb_ag32gbd_ram_rd.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ag32gbd_pkg.sv
// Shared constants and types for the ag32gbd cartridge RAM window logic.
// Used by both the read responder and the write/dither path.
package ag32gbd_pkg;

   localparam logic [2:0] RAM_WIN_PREFIX = 3'b101;
   localparam logic [4:0] REG_BANK_ID    = 5'h10;
   localparam logic [7:0] TIMEOUT_BYTE   = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRIVE = 2'd2,
      ST_DRAIN = 2'd3
   } rd_state_e;

   // Register space (bank 0x10 and up) lives elsewhere; only A000-BFFF photo banks hit here.
   function automatic logic is_ram_hit(input logic [2:0] addr_hi, input logic [4:0] bank);
      return (addr_hi == RAM_WIN_PREFIX) && ((bank & REG_BANK_ID) == 5'h00);
   endfunction

endpackage

// File: rtl/ag32gbd_sync2.sv
// Generic two-flop synchronizer for an asynchronous active-low strobe.
// Resets to 1 so an idle (high) strobe never produces a spurious edge.
module ag32gbd_sync2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/ag32gbd_ram_rd.sv
// Read responder for the camera photo RAM window: detects a Game Boy read,
// fetches one byte over the req/ack memory port and holds it for Cart_d.
module ag32gbd_ram_rd
   import ag32gbd_pkg::*;
#(
   parameter int ADDR_W  = 17,
   parameter int TIMEOUT = 31
) (
   input  logic              sys_clock,
   input  logic              sys_reset,
   input  logic [15:0]       Cart_a,
   input  logic              Cart_nRD,
   input  logic              Cart_nCS,
   input  logic [4:0]        Ram_bank_id,
   input  logic              Cam_Busy,
   output logic              Mem_Req,
   output logic [ADDR_W-1:0] Mem_Addr,
   input  logic              Mem_Ack,
   input  logic [7:0]        Mem_RdData,
   output logic              Rd_OutputValid,
   output logic [7:0]        Rd_OutputData,
   output logic              Rd_Timeout
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

   logic              ncs_sync_s, nrd_sync_s, hit_s;
   logic              ncs_prev_q;
   rd_state_e         state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              valid_q, valid_d;
   logic [7:0]        data_q, data_d;
   logic              tmo_q, tmo_d;
   logic [TMR_W-1:0]  timer_q, timer_d;

   ag32gbd_sync2 u_sync_ncs (.clk_i(sys_clock), .rst_i(sys_reset), .d_i(Cart_nCS), .q_o(ncs_sync_s));
   ag32gbd_sync2 u_sync_nrd (.clk_i(sys_clock), .rst_i(sys_reset), .d_i(Cart_nRD), .q_o(nrd_sync_s));

   // Cart_a and the bank are already stable when nCS falls, so they are sampled raw here.
   assign hit_s = ncs_prev_q && !ncs_sync_s && !nrd_sync_s
                  && is_ram_hit(Cart_a[15:13], Ram_bank_id);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      valid_d = valid_q;
      data_d  = data_q;
      tmo_d   = 1'b0;
      timer_d = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (hit_s && Cam_Busy) begin
               data_d  = 8'h00;
               valid_d = 1'b1;
               state_d = ST_DRIVE;
            end else if (hit_s) begin
               addr_d  = ADDR_W'({Ram_bank_id[3:0], Cart_a[12:0]});
               req_d   = 1'b1;
               timer_d = '0;
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Ack wins over both cancel and timeout; a cancelled ack leaves Valid low.
            if (Mem_Ack) begin
               req_d = 1'b0;
               if (ncs_sync_s) begin
                  state_d = ST_IDLE;
               end else begin
                  data_d  = Mem_RdData;
                  valid_d = 1'b1;
                  state_d = ST_DRIVE;
               end
            end else if (ncs_sync_s) begin
               state_d = ST_DRAIN;
            end else if (timer_q == TMR_MAX) begin
               data_d  = TIMEOUT_BYTE;
               valid_d = 1'b1;
               tmo_d   = 1'b1;
               state_d = ST_DRAIN;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_DRIVE: begin
            if (ncs_sync_s) begin
               valid_d = 1'b0;
               data_d  = 8'h00;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRIVE;
            end
         end
         ST_DRAIN: begin
            if (ncs_sync_s) begin
               valid_d = 1'b0;
               data_d  = 8'h00;
            end else begin
               valid_d = valid_q;
            end
            // The outstanding request must complete before the port can be reused.
            if (Mem_Ack) begin
               req_d   = 1'b0;
               state_d = ncs_sync_s ? ST_IDLE : ST_DRIVE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
            data_d  = 8'h00;
         end
      endcase
   end

   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         state_q    <= ST_IDLE;
         req_q      <= 1'b0;
         addr_q     <= '0;
         valid_q    <= 1'b0;
         data_q     <= 8'h00;
         tmo_q      <= 1'b0;
         timer_q    <= '0;
         ncs_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         tmo_q      <= tmo_d;
         timer_q    <= timer_d;
         ncs_prev_q <= ncs_sync_s;
      end
   end

   assign Mem_Req        = req_q;
   assign Mem_Addr       = addr_q;
   assign Rd_OutputValid = valid_q;
   assign Rd_OutputData  = data_q;
   assign Rd_Timeout     = tmo_q;

endmodule

// File: tb/tb_ag32gbd_ram_rd.sv
// Scoreboard bench for ag32gbd_ram_rd: directed reads push expected events,
// a monitor compares every request, valid edge and timeout pulse it observes.
module tb_ag32gbd_ram_rd;

   localparam int ADDR_W  = 17;
   localparam int TIMEOUT = 31;

   logic              sys_clock = 1'b0;
   logic              sys_reset;
   logic [15:0]       Cart_a;
   logic              Cart_nRD, Cart_nCS;
   logic [4:0]        Ram_bank_id;
   logic              Cam_Busy;
   logic              Mem_Req;
   logic [ADDR_W-1:0] Mem_Addr;
   logic              Mem_Ack;
   logic [7:0]        Mem_RdData;
   logic              Rd_OutputValid;
   logic [7:0]        Rd_OutputData;
   logic              Rd_Timeout;

   typedef enum logic [1:0] {EV_REQ, EV_VAL, EV_TMO, EV_DROP} ev_e;
   typedef struct packed {
      ev_e               kind;
      logic [ADDR_W-1:0] val;
   } ev_t;

   ev_t        exp_q[$];
   int         n_chk = 0;
   int         n_pass = 0;
   int         ack_delay = -1;
   logic [7:0] ack_data = 8'h00;
   bit         mon_en = 1'b0;
   bit         val_after_ack = 1'b0;

   ag32gbd_ram_rd #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .sys_clock(sys_clock), .sys_reset(sys_reset), .Cart_a(Cart_a),
      .Cart_nRD(Cart_nRD), .Cart_nCS(Cart_nCS), .Ram_bank_id(Ram_bank_id),
      .Cam_Busy(Cam_Busy), .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
      .Mem_Ack(Mem_Ack), .Mem_RdData(Mem_RdData), .Rd_OutputValid(Rd_OutputValid),
      .Rd_OutputData(Rd_OutputData), .Rd_Timeout(Rd_Timeout)
   );

   always #5 sys_clock = ~sys_clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic void expect_ev(input ev_e k, input logic [ADDR_W-1:0] v);
      exp_q.push_back(ev_t'{kind: k, val: v});
   endfunction

   task automatic observe(input ev_e k, input logic [ADDR_W-1:0] v);
      ev_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
         $display("FAIL sb_unexpected: got %s %0h, expected no event", k.name(), v);
      end else begin
         e = exp_q.pop_front();
         if ({k, v} === {e.kind, e.val}) n_pass++;
         else $display("FAIL sb_event: got %s %0h, expected %s %0h", k.name(), v, e.kind.name(), e.val);
      end
   endtask

   task automatic chk_empty(input string name);
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL %s: %0d expected events never seen, expected 0", name, exp_q.size());
      exp_q.delete();
   endtask

   // Memory responder: acks ack_delay+1 cycles after it first sees Mem_Req; -1 never acks.
   initial begin
      int req_cnt;
      req_cnt = 0;
      Mem_Ack = 1'b0;
      Mem_RdData = 8'h00;
      forever begin
         @(posedge sys_clock);
         #1;
         Mem_Ack = 1'b0;
         if (Mem_Req === 1'b1 && ack_delay >= 0) begin
            if (req_cnt == ack_delay) begin
               Mem_Ack = 1'b1;
               Mem_RdData = ack_data;
               req_cnt = 0;
            end else begin
               req_cnt++;
            end
         end else begin
            req_cnt = 0;
         end
      end
   end

   // Monitor: turns DUT output edges into events and hands them to the scoreboard.
   initial begin
      logic p_req, p_val, p_ack;
      p_req = 1'b0; p_val = 1'b0; p_ack = 1'b0;
      forever begin
         @(negedge sys_clock);
         if (mon_en) begin
            if (Mem_Req && !p_req) observe(EV_REQ, Mem_Addr);
            if (Rd_Timeout) observe(EV_TMO, ADDR_W'(Rd_OutputData));
            if (Rd_OutputValid && !p_val) begin
               observe(EV_VAL, ADDR_W'(Rd_OutputData));
               val_after_ack = p_ack;
            end
            if (!Rd_OutputValid && p_val) observe(EV_DROP, ADDR_W'(Rd_OutputData));
         end
         p_req = Mem_Req; p_val = Rd_OutputValid; p_ack = Mem_Ack;
      end
   end

   task automatic start_read(input logic [4:0] bank, input logic [15:0] a);
      @(negedge sys_clock);
      Ram_bank_id = bank; Cart_a = a; Cart_nRD = 1'b0;
      @(negedge sys_clock);
      Cart_nCS = 1'b0;
   endtask

   task automatic end_read();
      int k;
      k = 0;
      Cart_nCS = 1'b1; Cart_nRD = 1'b1;
      while (Rd_OutputValid && k < 3) begin
         @(negedge sys_clock);
         k++;
      end
      check("valid_release_3cyc", 32'(Rd_OutputValid), 32'd0);
      repeat (4) @(negedge sys_clock);
   endtask

   task automatic wait_req();
      int k;
      k = 0;
      while (!Mem_Req && k < 12) begin
         @(negedge sys_clock);
         k++;
      end
      check("req_seen", 32'(Mem_Req), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   32'(Mem_Req),        32'd0);
      check({tag, "_addr"},  32'(Mem_Addr),       32'd0);
      check({tag, "_valid"}, 32'(Rd_OutputValid), 32'd0);
      check({tag, "_data"},  32'(Rd_OutputData),  32'd0);
      check({tag, "_tmo"},   32'(Rd_Timeout),     32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1);
   end

   initial begin
      int cyc;
      sys_reset = 1'b1; Cart_a = 16'h0000; Cart_nRD = 1'b1; Cart_nCS = 1'b1;
      Ram_bank_id = 5'h00; Cam_Busy = 1'b0;
      repeat (4) @(negedge sys_clock);
      check_reset_outputs("reset");
      sys_reset = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(negedge sys_clock);

      // Normal read: bank 3, A123, ack 4 cycles after request.
      ack_delay = 3; ack_data = 8'h5A;
      expect_ev(EV_REQ, 17'h06123); expect_ev(EV_VAL, 17'h0005A); expect_ev(EV_DROP, 17'h00000);
      start_read(5'd3, 16'hA123);
      repeat (12) @(negedge sys_clock);
      check("ack_to_valid_1cyc", 32'(val_after_ack), 32'd1);
      check("normal_data_held", 32'(Rd_OutputData), 32'h5A);
      end_read();
      chk_empty("normal_read");

      // Busy camera: 0x00 without any memory access.
      Cam_Busy = 1'b1;
      expect_ev(EV_VAL, 17'h00000); expect_ev(EV_DROP, 17'h00000);
      start_read(5'd0, 16'hA000);
      repeat (6) @(negedge sys_clock);
      check("busy_valid", 32'(Rd_OutputValid), 32'd1);
      end_read();
      Cam_Busy = 1'b0;
      chk_empty("busy_read");

      // Register bank and out-of-window address: ignored.
      start_read(5'h10, 16'hA000);
      repeat (10) @(negedge sys_clock);
      check("regbank_no_valid", 32'(Rd_OutputValid), 32'd0);
      end_read();
      start_read(5'd0, 16'h4000);
      repeat (10) @(negedge sys_clock);
      check("rom_addr_no_valid", 32'(Rd_OutputValid), 32'd0);
      end_read();
      chk_empty("no_hit");

      // Timeout, then a late ack absorbed while draining.
      ack_delay = 40; ack_data = 8'hEE;
      expect_ev(EV_REQ, 17'h047FF); expect_ev(EV_TMO, 17'h000FF);
      expect_ev(EV_VAL, 17'h000FF); expect_ev(EV_DROP, 17'h00000);
      start_read(5'd2, 16'hA7FF);
      wait_req();
      cyc = 0;
      while (!Rd_Timeout && cyc < 60) begin
         @(negedge sys_clock);
         cyc++;
      end
      check("timeout_latency_ok", 32'(cyc >= TIMEOUT && cyc <= TIMEOUT + 1), 32'd1);
      cyc = 0;
      while (!Mem_Ack && cyc < 20) begin
         @(negedge sys_clock);
         cyc++;
      end
      check("late_ack_seen", 32'(Mem_Ack), 32'd1);
      repeat (4) @(negedge sys_clock);
      check("drain_valid_ff", {23'd0, Rd_OutputValid, Rd_OutputData}, 32'h1FF);
      check("drain_req_dropped", 32'(Mem_Req), 32'd0);
      end_read();
      chk_empty("timeout_read");

      // Cancel in WAIT: ack of 0x77 ten cycles later must not drive.
      ack_delay = 9; ack_data = 8'h77;
      expect_ev(EV_REQ, 17'h0C0F0);
      start_read(5'd6, 16'hA0F0);
      wait_req();
      Cart_nCS = 1'b1; Cart_nRD = 1'b1;
      repeat (16) @(negedge sys_clock);
      check("cancel_no_valid", 32'(Rd_OutputValid), 32'd0);
      check("cancel_req_done", 32'(Mem_Req), 32'd0);
      chk_empty("cancel_read");
      ack_delay = 1; ack_data = 8'h33;
      expect_ev(EV_REQ, 17'h02010); expect_ev(EV_VAL, 17'h00033); expect_ev(EV_DROP, 17'h00000);
      start_read(5'd1, 16'hA010);
      repeat (10) @(negedge sys_clock);
      end_read();
      chk_empty("after_cancel_read");

      // Reset while waiting, then a clean read.
      ack_delay = -1;
      expect_ev(EV_REQ, 17'h08555);
      start_read(5'd4, 16'hA555);
      wait_req();
      repeat (2) @(negedge sys_clock);
      sys_reset = 1'b1;
      @(negedge sys_clock);
      check_reset_outputs("midreset");
      Cart_nCS = 1'b1; Cart_nRD = 1'b1;
      repeat (3) @(negedge sys_clock);
      sys_reset = 1'b0;
      repeat (2) @(negedge sys_clock);
      chk_empty("reset_read");
      ack_delay = 2; ack_data = 8'hC3;
      expect_ev(EV_REQ, 17'h0B456); expect_ev(EV_VAL, 17'h000C3); expect_ev(EV_DROP, 17'h00000);
      start_read(5'd5, 16'hB456);
      repeat (10) @(negedge sys_clock);
      end_read();
      chk_empty("post_reset_read");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
